bnn_seq_ctrl: RTL and testbench

BNN_SEQ_CTRL -- requirements
Module: bnn_seq_ctrl

---
 rtl/bnn_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_bnn_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: sequences one binary-NN layer pass through a systolic array.
// Each pass loads O_CH weight rows contiguously, clears the array psums,
// streams ACT_LEN activations, waits DRAIN_CYC cycles for the psums to
// settle, then pops O_CH row results out through a one-entry output register.
//
// Optional feature macro: BNN_SEQ_WEIGHT_REUSE_EN (adds reuse_w_in, which
// lets a pass skip the weight load when a complete load is already resident).
//
// Ports:
//   clk_in, rst_in                 clock, asynchronous active-low reset
//   start_in / busy_out            pass request / pass in progress
//   done_out                       one-cycle pulse at the end of a pass
//   err_out                        sticky: weight stream broke mid-load
//   w_valid_in/w_ready_out/w_data_in   weight stream (9 bit)
//   a_valid_in/a_ready_out/a_data_in   activation stream (9 bit)
//   arr_data_out, arr_load_weight_out, arr_in_valid_out, arr_pop_out,
//   arr_rst_n_out, arr_sum_in      systolic array control and row result
//   res_valid_out/res_ready_in/res_data_out   row result stream
module bnn_seq_ctrl #(
    parameter int unsigned O_CH           = 64,
    parameter int unsigned OUT_ROW_LENGTH = 4,
    parameter int unsigned ACT_LEN        = 36,
    parameter int unsigned DRAIN_CYC      = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
`ifdef BNN_SEQ_WEIGHT_REUSE_EN
    input  logic                      reuse_w_in,
`endif
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      err_out,
    input  logic                      w_valid_in,
    output logic                      w_ready_out,
    input  logic [8:0]                w_data_in,
    input  logic                      a_valid_in,
    output logic                      a_ready_out,
    input  logic [8:0]                a_data_in,
    output logic [8:0]                arr_data_out,
    output logic                      arr_load_weight_out,
    output logic                      arr_in_valid_out,
    output logic                      arr_pop_out,
    output logic                      arr_rst_n_out,
    input  logic [OUT_ROW_LENGTH-1:0] arr_sum_in,
    output logic                      res_valid_out,
    input  logic                      res_ready_in,
    output logic [OUT_ROW_LENGTH-1:0] res_data_out
);

    localparam int unsigned CH_W  = $clog2(O_CH + 1);
    localparam int unsigned ACT_W = $clog2(ACT_LEN + 1);
    localparam int unsigned DR_W  = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_POP,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   w_cnt;
    logic [ACT_W-1:0]  a_cnt;
    logic [DR_W-1:0]   d_cnt;
    logic [CH_W-1:0]   pop_idx;
    logic [CH_W-1:0]   cap;
    logic              clr_c;
    logic              err_set_c;
    logic              w_done_c;
    logic              can_take_c;
    logic              capture_c;
    logic              reuse_ok_c;

`ifdef BNN_SEQ_WEIGHT_REUSE_EN
    logic w_loaded;

    // Weights stay resident in the array until an aborted load overwrites part of them.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            w_loaded <= 1'b0;
        end else if (w_done_c) begin
            w_loaded <= 1'b1;
        end else if (err_set_c) begin
            w_loaded <= 1'b0;
        end
    end

    assign reuse_ok_c = reuse_w_in && w_loaded;
`else
    assign reuse_ok_c = 1'b0;
`endif

    // Output register may accept a new row when empty or being drained this cycle.
    assign can_take_c = !res_valid_out || res_ready_in;
    // The array replays from row 0 after any pop gap; only the next unseen row is kept.
    assign capture_c  = arr_pop_out && (pop_idx == cap);

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and array/stream control.
    always_comb begin
        state_nxt           = state;
        busy_out            = 1'b1;
        w_ready_out         = 1'b0;
        a_ready_out         = 1'b0;
        arr_data_out        = '0;
        arr_load_weight_out = 1'b0;
        arr_in_valid_out    = 1'b0;
        arr_pop_out         = 1'b0;
        clr_c               = 1'b0;
        err_set_c           = 1'b0;
        w_done_c            = 1'b0;
        case (state)
            S_IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    state_nxt = reuse_ok_c ? S_CLR : S_LOADW;
                end
            end
            S_LOADW: begin
                w_ready_out         = 1'b1;
                arr_data_out        = w_data_in;
                arr_load_weight_out = w_valid_in;
                if (w_valid_in) begin
                    if (w_cnt == CH_W'(O_CH - 1)) begin
                        w_done_c  = 1'b1;
                        state_nxt = S_CLR;
                    end
                end else if (w_cnt != '0) begin
                    // A gap restarts the array weight index, so the partial load is useless.
                    err_set_c = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_CLR: begin
                clr_c     = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                a_ready_out      = 1'b1;
                arr_in_valid_out = a_valid_in;
                arr_data_out     = a_data_in;
                if (a_valid_in && (a_cnt == ACT_W'(ACT_LEN - 1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (d_cnt == DR_W'(DRAIN_CYC - 1)) begin
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                arr_pop_out = can_take_c && (cap < CH_W'(O_CH));
                if ((cap == CH_W'(O_CH)) && !res_valid_out) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign done_out      = (state == S_DONE);
    // Psum clear is also held while this block is in reset.
    assign arr_rst_n_out = rst_in && !clr_c;

    // Phase counters; each runs only in its own state and rests at zero otherwise.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            w_cnt   <= '0;
            a_cnt   <= '0;
            d_cnt   <= '0;
            pop_idx <= '0;
            cap     <= '0;
        end else begin
            if (state != S_LOADW) begin
                w_cnt <= '0;
            end else if (w_valid_in) begin
                w_cnt <= w_cnt + CH_W'(1);
            end

            if (state != S_STREAM) begin
                a_cnt <= '0;
            end else if (a_valid_in) begin
                a_cnt <= a_cnt + ACT_W'(1);
            end

            if (state != S_DRAIN) begin
                d_cnt <= '0;
            end else begin
                d_cnt <= d_cnt + DR_W'(1);
            end

            // Mirrors the array's pop index, which resets whenever pop drops.
            if (arr_pop_out) begin
                pop_idx <= pop_idx + CH_W'(1);
            end else begin
                pop_idx <= '0;
            end

            if (state != S_POP) begin
                cap <= '0;
            end else if (capture_c) begin
                cap <= cap + CH_W'(1);
            end
        end
    end

    // One-entry result register and sticky error flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            res_valid_out <= 1'b0;
            res_data_out  <= '0;
            err_out       <= 1'b0;
        end else begin
            if (capture_c) begin
                res_valid_out <= 1'b1;
                res_data_out  <= arr_sum_in;
            end else if (res_ready_in) begin
                res_valid_out <= 1'b0;
            end

            if (err_set_c) begin
                err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb_bnn_seq_ctrl: directed bench for bnn_seq_ctrl with a small array model
// that replays rows from index 0 whenever pop drops.
module tb_bnn_seq_ctrl;

    localparam int unsigned O_CH           = 4;
    localparam int unsigned OUT_ROW_LENGTH = 4;
    localparam int unsigned ACT_LEN        = 3;
    localparam int unsigned DRAIN_CYC      = 4;

    logic       clk_in;
    logic       rst_in;
    logic       start_in;
    logic       reuse_w_in;
    logic       busy_out, done_out, err_out;
    logic       w_valid_in, w_ready_out;
    logic [8:0] w_data_in;
    logic       a_valid_in, a_ready_out;
    logic [8:0] a_data_in;
    logic [8:0] arr_data_out;
    logic       arr_load_weight_out, arr_in_valid_out, arr_pop_out, arr_rst_n_out;
    logic [3:0] arr_sum_in;
    logic       res_valid_out, res_ready_in;
    logic [3:0] res_data_out;

    bnn_seq_ctrl #(
        .O_CH(O_CH), .OUT_ROW_LENGTH(OUT_ROW_LENGTH),
        .ACT_LEN(ACT_LEN), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
`ifdef BNN_SEQ_WEIGHT_REUSE_EN
        .reuse_w_in(reuse_w_in),
`endif
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
        .w_valid_in(w_valid_in), .w_ready_out(w_ready_out), .w_data_in(w_data_in),
        .a_valid_in(a_valid_in), .a_ready_out(a_ready_out), .a_data_in(a_data_in),
        .arr_data_out(arr_data_out), .arr_load_weight_out(arr_load_weight_out),
        .arr_in_valid_out(arr_in_valid_out), .arr_pop_out(arr_pop_out),
        .arr_rst_n_out(arr_rst_n_out), .arr_sum_in(arr_sum_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .res_data_out(res_data_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [3:0] row_vals [4];
    logic [8:0] wvec [4];
    logic [8:0] avec [5];
    logic [2:0] arr_idx;

    // Array model: row result for the current pop index; index restarts when pop drops.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)          arr_idx <= 3'd0;
        else if (arr_pop_out) arr_idx <= arr_idx + 3'd1;
        else                  arr_idx <= 3'd0;
    end
    assign arr_sum_in = arr_idx[2] ? 4'h0 : row_vals[arr_idx[1:0]];

    logic [3:0] rx_q [$];
    int load_cyc, clr_cyc, done_cyc;
    int n_checks, n_errors;

    // Observers sampled mid-cycle.
    always @(negedge clk_in) begin
        if (res_valid_out && res_ready_in) rx_q.push_back(res_data_out);
        if (arr_load_weight_out) load_cyc++;
        if (!arr_rst_n_out && rst_in) clr_cyc++;
        if (done_out) done_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic load_weights();
        check("loadw_ready", 32'(w_ready_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            w_valid_in = 1'b1;
            w_data_in  = wvec[i];
            #1;
            check("loadw_load", 32'(arr_load_weight_out), 32'd1);
            check("loadw_data", 32'(arr_data_out), 32'(wvec[i]));
            tick();
        end
        w_valid_in = 1'b0;
        w_data_in  = 9'd0;
    endtask

    task automatic clr_cycle();
        check("clr_low", 32'(arr_rst_n_out), 32'd0);
        check("clr_wready", 32'(w_ready_out), 32'd0);
        check("clr_data", 32'(arr_data_out), 32'd0);
        tick();
        check("stream_rstn", 32'(arr_rst_n_out), 32'd1);
    endtask

    task automatic stream(input logic [4:0] pat, input int len);
        for (int i = 0; i < len; i++) begin
            a_valid_in = pat[i];
            a_data_in  = avec[i];
            #1;
            check("stream_ready", 32'(a_ready_out), 32'd1);
            check("stream_ivalid", 32'(arr_in_valid_out), 32'(pat[i]));
            if (pat[i]) check("stream_data", 32'(arr_data_out), 32'(avec[i]));
            tick();
        end
        a_valid_in = 1'b0;
        a_data_in  = 9'd0;
        check("drain_aready", 32'(a_ready_out), 32'd0);
    endtask

    task automatic drain();
        repeat (3) tick();
        check("drain_nopop", 32'(arr_pop_out), 32'd0);
        tick();
        check("pop_start", 32'(arr_pop_out), 32'd1);
    endtask

    task automatic finish_pass();
        res_ready_in = 1'b1;
        for (int i = 0; i < 40 && !done_out; i++) tick();
        check("done_seen", 32'(done_out), 32'd1);
        tick();
        check("idle_busy", 32'(busy_out), 32'd0);
    endtask

    task automatic check_rows();
        check("row_count", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) check("row_data", 32'(rx_q[i]), 32'(row_vals[i]));
    endtask

    int l0, c0, d0;

    initial begin
        row_vals = '{4'hA, 4'h5, 4'hC, 4'h3};
        wvec     = '{9'h101, 9'h0A5, 9'h1FF, 9'h003};
        avec     = '{9'h011, 9'h122, 9'h033, 9'h144, 9'h055};
        n_checks = 0; n_errors = 0;
        rst_in = 1'b0; start_in = 1'b0; reuse_w_in = 1'b0;
        w_valid_in = 1'b0; w_data_in = 9'd0;
        a_valid_in = 1'b0; a_data_in = 9'd0;
        res_ready_in = 1'b0;

        // Reset values
        #1;
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_rvalid", 32'(res_valid_out), 32'd0);
        check("rst_rdata", 32'(res_data_out), 32'd0);
        check("rst_arr_rstn", 32'(arr_rst_n_out), 32'd0);
        check("rst_arr_ctl", 32'({arr_load_weight_out, arr_in_valid_out, arr_pop_out}), 32'd0);
        check("rst_arr_data", 32'(arr_data_out), 32'd0);
        tick(); tick();
        rst_in = 1'b1;
        tick();

        // Nominal pass
        rx_q.delete(); l0 = load_cyc; c0 = clr_cyc; d0 = done_cyc;
        start_in = 1'b1;
        #1;
        check("idle_wready", 32'(w_ready_out), 32'd0);
        tick();
        start_in = 1'b0;
        check("loadw_busy", 32'(busy_out), 32'd1);
        load_weights();
        clr_cycle();
        stream(5'b00111, 3);
        drain();
        finish_pass();
        check("nom_load_cyc", 32'(load_cyc - l0), 32'd4);
        check("nom_clr_cyc", 32'(clr_cyc - c0), 32'd1);
        check("nom_done_cyc", 32'(done_cyc - d0), 32'd1);
        check_rows();

        // Weight gap at beat 2
        c0 = clr_cyc;
        do_start();
        w_valid_in = 1'b1; w_data_in = wvec[0];
        tick();
        w_valid_in = 1'b0;
        #1;
        check("gap_load", 32'(arr_load_weight_out), 32'd0);
        tick();
        check("gap_err", 32'(err_out), 32'd1);
        check("gap_idle", 32'(busy_out), 32'd0);
        tick();
        check("gap_no_clr", 32'(clr_cyc - c0), 32'd0);

        // Activation gaps 1,0,0,1,1
        rx_q.delete();
        do_start();
        load_weights();
        clr_cycle();
        stream(5'b11001, 5);
        drain();
        finish_pass();
        check_rows();
        check("err_sticky", 32'(err_out), 32'd1);

        // Result backpressure after row 1
        rx_q.delete();
        do_start();
        load_weights();
        clr_cycle();
        stream(5'b00111, 3);
        res_ready_in = 1'b1;
        drain();
        for (int i = 0; i < 20 && rx_q.size() < 2; i++) tick();
        check("bp_two_rows", 32'(rx_q.size()), 32'd2);
        res_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_pop_drop", 32'(arr_pop_out), 32'd0);
            check("bp_valid", 32'(res_valid_out), 32'd1);
            check("bp_stable", 32'(res_data_out), 32'hC);
            tick();
        end
        finish_pass();
        check_rows();

        // Async reset during POP with two rows captured
        do_start();
        load_weights();
        clr_cycle();
        stream(5'b00111, 3);
        res_ready_in = 1'b1;
        drain();
        tick(); tick();
        res_ready_in = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        check("ar_rvalid", 32'(res_valid_out), 32'd0);
        check("ar_rdata", 32'(res_data_out), 32'd0);
        check("ar_busy", 32'(busy_out), 32'd0);
        check("ar_pop", 32'(arr_pop_out), 32'd0);
        check("ar_rstn", 32'(arr_rst_n_out), 32'd0);
        check("ar_err", 32'(err_out), 32'd0);
        tick();
        rst_in = 1'b1;
        rx_q.delete();
        res_ready_in = 1'b1;
        tick(); tick();
        check("ar_no_hs", 32'(rx_q.size()), 32'd0);
        res_ready_in = 1'b0;
        do_start();
        load_weights();
        clr_cycle();
        stream(5'b00111, 3);
        drain();
        finish_pass();
        check_rows();

`ifdef BNN_SEQ_WEIGHT_REUSE_EN
        // Reuse resident weights
        rx_q.delete(); l0 = load_cyc;
        reuse_w_in = 1'b1;
        do_start();
        reuse_w_in = 1'b0;
        clr_cycle();
        stream(5'b00111, 3);
        drain();
        finish_pass();
        check("reuse_no_load", 32'(load_cyc - l0), 32'd0);
        check_rows();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
